// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - fetch-stage program counter with a circular return-address stack
// Priority: reset > stall > ret > call > jump > branch > increment.
module pc_ras #(
  parameter int D         = 6,
  parameter int OFF_W     = 6,
  parameter int RAS_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             jump_en,
  input  logic [D-1:0]                     target,
  input  logic                             branch_en,
  input  logic [OFF_W-1:0]                 offset,
  input  logic                             call_en,
  input  logic                             ret_en,
  output logic [D-1:0]                     prog_ctr,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_overflow,
  output logic                             ras_underflow
);

  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int MW = (D > OFF_W) ? D : OFF_W;
  localparam logic [PW-1:0] LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

  logic [D-1:0]  stack [RAS_DEPTH];
  // top_ptr is the next slot to write; a push while full lands on the oldest entry.
  logic [PW-1:0] top_ptr;
  logic [PW-1:0] ptr_inc;
  logic [PW-1:0] ptr_dec;
  logic [MW-1:0] off_ext;
  logic [D-1:0]  pc_inc;
  logic [D-1:0]  pc_branch;

  always_comb begin
    ptr_inc   = (top_ptr == LAST) ? '0 : top_ptr + PW'(1);
    ptr_dec   = (top_ptr == '0) ? LAST : top_ptr - PW'(1);
    off_ext   = MW'($signed(offset));
    pc_inc    = prog_ctr + D'(1);
    pc_branch = prog_ctr + off_ext[D-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr      <= '0;
      ras_count     <= '0;
      top_ptr       <= '0;
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      ras_overflow  <= 1'b0;
      ras_underflow <= 1'b0;
      if (stall) begin
        prog_ctr <= prog_ctr;
      end else if (ret_en) begin
        if (ras_count != '0) begin
          prog_ctr  <= stack[ptr_dec];
          top_ptr   <= ptr_dec;
          ras_count <= ras_count - CW'(1);
        end else begin
          ras_underflow <= 1'b1;
          prog_ctr      <= pc_inc;
        end
      end else if (call_en) begin
        stack[top_ptr] <= pc_inc;
        top_ptr        <= ptr_inc;
        prog_ctr       <= target;
        if (ras_count == FULL) ras_overflow <= 1'b1;
        else                   ras_count    <= ras_count + CW'(1);
      end else if (jump_en) begin
        prog_ctr <= target;
      end else if (branch_en) begin
        prog_ctr <= pc_branch;
      end else begin
        prog_ctr <= pc_inc;
      end
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// tb/tb_pc_ras.sv - directed plan plus randomized steps against a queue-based reference
module tb_pc_ras;
  localparam int D = 6;
  localparam int OFF_W = 6;
  localparam int RD = 4;
  localparam int CW = $clog2(RD + 1);
  localparam int M = (1 << D) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0, stall = 1'b0, jump_en = 1'b0, branch_en = 1'b0;
  logic call_en = 1'b0, ret_en = 1'b0;
  logic [D-1:0] target = '0;
  logic [OFF_W-1:0] offset = '0;
  logic [D-1:0] prog_ctr;
  logic [CW-1:0] ras_count;
  logic ras_overflow, ras_underflow;

  int tests = 0;
  int fails = 0;
  int m_pc = 0;
  int m_q[$];
  bit m_ovf, m_unf;

  pc_ras #(.D(D), .OFF_W(OFF_W), .RAS_DEPTH(RD)) dut (
    .clk(clk), .reset(reset), .stall(stall), .jump_en(jump_en), .target(target),
    .branch_en(branch_en), .offset(offset), .call_en(call_en), .ret_en(ret_en),
    .prog_ctr(prog_ctr), .ras_count(ras_count), .ras_overflow(ras_overflow),
    .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive controls, advance the reference model, compare all outputs.
  task automatic step(input string tag, input bit rs, input bit s, input bit c, input bit r,
                      input bit j, input bit b, input int t, input int o);
    int so;
    reset = rs; stall = s; call_en = c; ret_en = r; jump_en = j; branch_en = b;
    target = t[D-1:0]; offset = o[OFF_W-1:0];
    @(posedge clk);
    m_ovf = 0; m_unf = 0;
    so = o & ((1 << OFF_W) - 1);
    if (so >= (1 << (OFF_W - 1))) so -= (1 << OFF_W);
    if (rs) begin
      m_pc = 0; m_q.delete();
    end else if (s) begin
      m_pc = m_pc;
    end else if (r) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin m_unf = 1; m_pc = (m_pc + 1) & M; end
    end else if (c) begin
      m_q.push_back((m_pc + 1) & M);
      if (m_q.size() > RD) begin void'(m_q.pop_front()); m_ovf = 1; end
      m_pc = t & M;
    end else if (j) m_pc = t & M;
    else if (b) m_pc = (m_pc + so) & M;
    else m_pc = (m_pc + 1) & M;
    #1;
    chk({tag, ".pc"}, 32'(prog_ctr), 32'(m_pc));
    chk({tag, ".cnt"}, 32'(ras_count), 32'(m_q.size()));
    chk({tag, ".ovf"}, 32'(ras_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(ras_underflow), 32'(m_unf));
  endtask

  task automatic idle(input string tag);  step(tag, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(input string tag, input int t);  step(tag, 0, 0, 0, 0, 1, 0, t, 0); endtask
  task automatic br(input string tag, input int o);  step(tag, 0, 0, 0, 0, 0, 1, 0, o); endtask
  task automatic call(input string tag, input int t);  step(tag, 0, 0, 1, 0, 0, 0, t, 0); endtask
  task automatic ret(input string tag);  step(tag, 0, 0, 0, 1, 0, 0, 0, 0); endtask

  initial begin
    #1;
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset_pc", 32'(prog_ctr), 0);
    for (int i = 1; i <= 4; i++) begin
      idle("inc");
      chk("inc_abs", 32'(prog_ctr), 32'(i));
    end

    jmp("jump", 5);      chk("jump_abs", 32'(prog_ctr), 5);
    idle("inc6"); idle("inc7"); chk("inc7_abs", 32'(prog_ctr), 7);
    jmp("j62", 62); idle("to63"); idle("wrap");
    chk("wrap_abs", 32'(prog_ctr), 0);
    jmp("j10", 10); br("br_neg", 6'b111101); chk("br_neg_abs", 32'(prog_ctr), 7);
    jmp("j60", 60); br("br_pos", 5);         chk("br_pos_abs", 32'(prog_ctr), 1);

    jmp("j3", 3); call("call20", 20);
    chk("call20_abs", 32'(prog_ctr), 20); chk("call20_cnt", 32'(ras_count), 1);
    idle("c_inc"); idle("c_inc"); call("call40", 40);
    chk("call40_cnt", 32'(ras_count), 2);
    ret("ret1"); chk("ret1_abs", 32'(prog_ctr), 23);
    ret("ret2"); chk("ret2_abs", 32'(prog_ctr), 4); chk("ret2_cnt", 32'(ras_count), 0);

    jmp("j0", 0);
    for (int i = 1; i <= 5; i++) begin
      call("nest", i * 10);
      chk("nest_ovf", 32'(ras_overflow), (i == 5) ? 1 : 0);
    end
    chk("nest_cnt", 32'(ras_count), 4);
    for (int i = 4; i >= 1; i--) begin
      ret("unwind");
      chk("unwind_abs", 32'(prog_ctr), 32'(i * 10 + 1));
    end
    ret("under"); chk("under_flag", 32'(ras_underflow), 1);
    chk("under_abs", 32'(prog_ctr), 12);

    for (int i = 0; i < 3; i++) step("stall_call", 0, 1, 1, 0, 0, 0, 50, 0);
    chk("stall_abs", 32'(prog_ctr), 12);
    call("pc30", 30);
    step("ret_call", 0, 0, 1, 1, 0, 0, 40, 0);
    chk("ret_call_abs", 32'(prog_ctr), 13); chk("ret_call_cnt", 32'(ras_count), 0);
    step("jmp_br", 0, 0, 0, 0, 1, 1, 7, 5); chk("jmp_br_abs", 32'(prog_ctr), 7);

    call("mid1", 20); call("mid2", 30);
    step("mid_reset", 1, 0, 0, 1, 0, 0, 0, 0);
    chk("mid_reset_cnt", 32'(ras_count), 0);
    ret("post_reset_ret");
    chk("post_reset_unf", 32'(ras_underflow), 1); chk("post_reset_pc", 32'(prog_ctr), 1);

    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 99);
      step("rand", k < 2, (k >= 2 && k < 12), (k >= 12 && k < 35), (k >= 30 && k < 55),
           (k >= 50 && k < 65) || (k >= 90), (k >= 60 && k < 75) || (k >= 95),
           int'($urandom_range(0, M)), int'($urandom_range(0, (1 << OFF_W) - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
